// File: rtl/fft_frame_ctrl.sv
// fft_frame_ctrl
//   Frame controller wrapped around an in-place radix-2 FFT core. It owns the
//   complex sample buffer. Each frame runs through these steps:
//     1. Stream in N samples, in bit-reversed or natural order.
//     2. Launch the core.
//     3. Write the core's butterfly results back every cycle.
//     4. Deliver the transformed frame, either as an output stream or by
//        saturated random-access inspection.
//
// Ports
//   Clk, Reset_n        rising-edge clock, asynchronous active-low reset
//   Start               launch request (WAIT only)
//   Mode                0 = stream results out, 1 = hold for inspection
//   Clear               leave HOLD
//   Abort               discard the frame from any state
//   In_*                input sample stream (valid/ready)
//   Core_*              butterfly interface to the FFT core
//   Out_*               result stream (valid/ready) with index and last flag
//   Inspect/Result*     hold-mode inspection port, 1-cycle latency
//   Busy, Frame_Count   status
module fft_frame_ctrl #(
    parameter int unsigned LOG2N      = 8,
    parameter int unsigned DW         = 32,
    parameter int unsigned OUT_W      = 16,
    parameter int unsigned BITREV_IN  = 1,
    parameter int unsigned AUTO_START = 0
) (
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic             Start,
    input  logic             Mode,
    input  logic             Clear,
    input  logic             Abort,
    input  logic             In_Valid,
    output logic             In_Ready,
    input  logic [DW-1:0]    In_Re,
    input  logic [DW-1:0]    In_Im,
    output logic             Core_Start,
    output logic             Core_Abort,
    input  logic [LOG2N-1:0] Core_i_top,
    input  logic [LOG2N-1:0] Core_i_bot,
    output logic [DW-1:0]    Core_x_top_re,
    output logic [DW-1:0]    Core_x_top_im,
    output logic [DW-1:0]    Core_x_bot_re,
    output logic [DW-1:0]    Core_x_bot_im,
    input  logic [DW-1:0]    Core_y_top_re,
    input  logic [DW-1:0]    Core_y_top_im,
    input  logic [DW-1:0]    Core_y_bot_re,
    input  logic [DW-1:0]    Core_y_bot_im,
    input  logic             Core_Done,
    output logic             Out_Valid,
    input  logic             Out_Ready,
    output logic [DW-1:0]    Out_Re,
    output logic [DW-1:0]    Out_Im,
    output logic [LOG2N-1:0] Out_Index,
    output logic             Out_Last,
    input  logic [LOG2N-1:0] Inspect,
    output logic [OUT_W-1:0] Result,
    output logic             Result_Valid,
    output logic             Busy,
    output logic [15:0]      Frame_Count
);

    localparam int unsigned N = 1 << LOG2N;
    localparam logic [LOG2N-1:0] LastIdx = {LOG2N{1'b1}};

    // Saturation compare width: wide enough for both DW and OUT_W plus a sign
    // guard, so the clamp limits never overflow.
    localparam int unsigned CW = ((DW > OUT_W) ? DW : OUT_W) + 1;

    typedef enum logic [4:0] {
        StLoad   = 5'b00001,
        StWait   = 5'b00010,
        StRun    = 5'b00100,
        StUnload = 5'b01000,
        StHold   = 5'b10000
    } state_e;

    state_e             state_q, state_d;
    logic [LOG2N-1:0]   wr_ptr_q, wr_ptr_d;
    logic [LOG2N-1:0]   rd_ptr_q, rd_ptr_d;
    logic [15:0]        frame_cnt_q, frame_cnt_d;
    logic               core_start_q;
    logic               core_abort_q;
    logic [OUT_W-1:0]   result_q, result_d;
    logic               result_valid_q, result_valid_d;

    // Sample buffer; deliberately not reset.
    logic [DW-1:0]      mem_re [N];
    logic [DW-1:0]      mem_im [N];

    logic [LOG2N-1:0]   load_addr;
    logic               load_wr_en;
    logic               run_wr_en;

    logic signed [CW-1:0] sat_ext;
    logic signed [CW-1:0] sat_max;
    logic signed [CW-1:0] sat_min;
    logic [OUT_W-1:0]     sat_val;
    logic [DW-1:0]        inspect_re;

    function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] a);
        logic [LOG2N-1:0] r;
        for (int i = 0; i < int'(LOG2N); i++) begin
            r[i] = a[int'(LOG2N) - 1 - i];
        end
        return r;
    endfunction

    assign load_addr = (BITREV_IN == 1) ? bitrev(wr_ptr_q) : wr_ptr_q;

    // An aborted final accept drops its sample. Writes are also gated while
    // Reset_n is low, because the buffer itself has no reset.
    assign load_wr_en = (state_q == StLoad) & In_Valid & ~Abort & Reset_n;

    // No write-back on the launch cycle or on the done cycle.
    assign run_wr_en = (state_q == StRun) & ~core_start_q & ~Core_Done & ~Abort & Reset_n;

    // Buffer write port. The top write is issued last so it wins on an
    // i_top == i_bot collision.
    always_ff @(posedge Clk) begin
        if (load_wr_en) begin
            mem_re[load_addr] <= In_Re;
            mem_im[load_addr] <= In_Im;
        end
        if (run_wr_en) begin
            mem_re[Core_i_bot] <= Core_y_bot_re;
            mem_im[Core_i_bot] <= Core_y_bot_im;
            mem_re[Core_i_top] <= Core_y_top_re;
            mem_im[Core_i_top] <= Core_y_top_im;
        end
    end

    // Saturate the inspected real part to the signed OUT_W range.
    always_comb begin
        inspect_re = mem_re[Inspect];
        sat_ext    = {{(CW - DW){inspect_re[DW-1]}}, inspect_re};
        sat_max    = {{(CW - OUT_W + 1){1'b0}}, {(OUT_W - 1){1'b1}}};
        sat_min    = ~sat_max;
        if (sat_ext > sat_max) begin
            sat_val = sat_max[OUT_W-1:0];
        end else if (sat_ext < sat_min) begin
            sat_val = sat_min[OUT_W-1:0];
        end else begin
            sat_val = sat_ext[OUT_W-1:0];
        end
    end

    // Next-state logic
    always_comb begin
        state_d        = state_q;
        wr_ptr_d       = wr_ptr_q;
        rd_ptr_d       = rd_ptr_q;
        frame_cnt_d    = frame_cnt_q;
        result_d       = result_q;
        result_valid_d = 1'b0;

        if (Abort) begin
            state_d  = StLoad;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            unique case (state_q)
                StLoad: begin
                    if (In_Valid) begin
                        wr_ptr_d = wr_ptr_q + 1'b1;
                        if (wr_ptr_q == LastIdx) begin
                            state_d = (AUTO_START == 1) ? StRun : StWait;
                        end
                    end
                end
                StWait: begin
                    if (Start) begin
                        state_d = StRun;
                    end
                end
                StRun: begin
                    if (Core_Done) begin
                        frame_cnt_d = frame_cnt_q + 16'd1;
                        state_d     = Mode ? StHold : StUnload;
                    end
                end
                StUnload: begin
                    if (Out_Ready) begin
                        rd_ptr_d = rd_ptr_q + 1'b1;
                        if (rd_ptr_q == LastIdx) begin
                            state_d = StLoad;
                        end
                    end
                end
                StHold: begin
                    if (Clear) begin
                        state_d = StLoad;
                    end else begin
                        result_d       = sat_val;
                        result_valid_d = 1'b1;
                    end
                end
                default: begin
                    state_d = StLoad;
                end
            endcase
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q        <= StLoad;
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            frame_cnt_q    <= '0;
            core_start_q   <= 1'b0;
            core_abort_q   <= 1'b0;
            result_q       <= '0;
            result_valid_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            frame_cnt_q    <= frame_cnt_d;
            // High for the first RUN cycle on every entry into RUN.
            core_start_q   <= (state_d == StRun) && (state_q != StRun);
            core_abort_q   <= Abort && (state_q == StRun);
            result_q       <= result_d;
            result_valid_q <= result_valid_d;
        end
    end

    assign In_Ready      = (state_q == StLoad);
    assign Busy          = (state_q == StRun);
    assign Core_Start    = core_start_q;
    assign Core_Abort    = core_abort_q;

    assign Core_x_top_re = mem_re[Core_i_top];
    assign Core_x_top_im = mem_im[Core_i_top];
    assign Core_x_bot_re = mem_re[Core_i_bot];
    assign Core_x_bot_im = mem_im[Core_i_bot];

    assign Out_Valid     = (state_q == StUnload);
    assign Out_Re        = mem_re[rd_ptr_q];
    assign Out_Im        = mem_im[rd_ptr_q];
    assign Out_Index     = rd_ptr_q;
    assign Out_Last      = Out_Valid && (rd_ptr_q == LastIdx);

    assign Result        = result_q;
    assign Result_Valid  = result_valid_q;
    assign Frame_Count   = frame_cnt_q;

endmodule

// File: tb/tb_fft_frame_ctrl.sv
// tb_fft_frame_ctrl
//   Drives two controller instances: a bit-reversed, manually started one
//   and a natural-order, auto-start one. A stub core is played from the
//   tasks. Expected buffer contents come from a plain array model of the
//   frame.
module tb_fft_frame_ctrl;

    localparam int N = 8;

    logic        clk;
    logic        rst_n;

    // Main instance: BITREV_IN = 1, AUTO_START = 0
    logic        start, mode, clear, abort_req;
    logic        in_valid, in_ready;
    logic [31:0] in_re, in_im;
    logic        core_start, core_abort, core_done;
    logic [2:0]  i_top, i_bot;
    logic [31:0] x_top_re, x_top_im, x_bot_re, x_bot_im;
    logic [31:0] y_top_re, y_top_im, y_bot_re, y_bot_im;
    logic        out_valid, out_ready, out_last;
    logic [31:0] out_re, out_im;
    logic [2:0]  out_index, inspect;
    logic [15:0] result, frame_count;
    logic        result_valid, busy;

    // Auto-start instance: BITREV_IN = 0, AUTO_START = 1
    logic        a_start, a_mode, a_clear, a_abort;
    logic        a_in_valid, a_in_ready;
    logic [31:0] a_in_re, a_in_im;
    logic        a_core_start, a_core_abort, a_core_done;
    logic [2:0]  a_i_top, a_i_bot;
    logic [31:0] a_x_top_re, a_x_top_im, a_x_bot_re, a_x_bot_im;
    logic [31:0] a_y_top_re, a_y_top_im, a_y_bot_re, a_y_bot_im;
    logic        a_out_valid, a_out_ready, a_out_last;
    logic [31:0] a_out_re, a_out_im;
    logic [2:0]  a_out_index, a_inspect;
    logic [15:0] a_result, a_frame_count;
    logic        a_result_valid, a_busy;

    logic [31:0] model_re [N];
    logic [31:0] model_im [N];
    int          fc_model;
    int          n_checks;
    int          n_pass;

    fft_frame_ctrl #(
        .LOG2N(3), .DW(32), .OUT_W(16), .BITREV_IN(1), .AUTO_START(0)
    ) u_dut (
        .Clk(clk), .Reset_n(rst_n), .Start(start), .Mode(mode), .Clear(clear),
        .Abort(abort_req), .In_Valid(in_valid), .In_Ready(in_ready), .In_Re(in_re),
        .In_Im(in_im), .Core_Start(core_start), .Core_Abort(core_abort),
        .Core_i_top(i_top), .Core_i_bot(i_bot), .Core_x_top_re(x_top_re),
        .Core_x_top_im(x_top_im), .Core_x_bot_re(x_bot_re), .Core_x_bot_im(x_bot_im),
        .Core_y_top_re(y_top_re), .Core_y_top_im(y_top_im), .Core_y_bot_re(y_bot_re),
        .Core_y_bot_im(y_bot_im), .Core_Done(core_done), .Out_Valid(out_valid),
        .Out_Ready(out_ready), .Out_Re(out_re), .Out_Im(out_im), .Out_Index(out_index),
        .Out_Last(out_last), .Inspect(inspect), .Result(result),
        .Result_Valid(result_valid), .Busy(busy), .Frame_Count(frame_count)
    );

    fft_frame_ctrl #(
        .LOG2N(3), .DW(32), .OUT_W(16), .BITREV_IN(0), .AUTO_START(1)
    ) u_auto (
        .Clk(clk), .Reset_n(rst_n), .Start(a_start), .Mode(a_mode), .Clear(a_clear),
        .Abort(a_abort), .In_Valid(a_in_valid), .In_Ready(a_in_ready), .In_Re(a_in_re),
        .In_Im(a_in_im), .Core_Start(a_core_start), .Core_Abort(a_core_abort),
        .Core_i_top(a_i_top), .Core_i_bot(a_i_bot), .Core_x_top_re(a_x_top_re),
        .Core_x_top_im(a_x_top_im), .Core_x_bot_re(a_x_bot_re),
        .Core_x_bot_im(a_x_bot_im), .Core_y_top_re(a_y_top_re),
        .Core_y_top_im(a_y_top_im), .Core_y_bot_re(a_y_bot_re),
        .Core_y_bot_im(a_y_bot_im), .Core_Done(a_core_done), .Out_Valid(a_out_valid),
        .Out_Ready(a_out_ready), .Out_Re(a_out_re), .Out_Im(a_out_im),
        .Out_Index(a_out_index), .Out_Last(a_out_last), .Inspect(a_inspect),
        .Result(a_result), .Result_Valid(a_result_valid), .Busy(a_busy),
        .Frame_Count(a_frame_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish within the time limit");
        $fatal(1, "watchdog expired");
    end

    // 3-bit bit reversal done arithmetically.
    function automatic int rev3(input int k);
        int r;
        int v;
        r = 0;
        v = k;
        for (int i = 0; i < 3; i++) begin
            r = r * 2 + v % 2;
            v = v / 2;
        end
        return r;
    endfunction

    function automatic logic [15:0] sat_model(input logic [31:0] v);
        longint s;
        logic [15:0] r;
        s = $signed(v);
        if (s > 32767) r = 16'h7fff;
        else if (s < -32768) r = 16'h8000;
        else r = 16'(s);
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Streams nsamp samples into the main instance, with random idle gaps.
    // If abort_last is set, Abort rides along with the final accept and the
    // model keeps the old contents at that address.
    task automatic load_frame(input int nsamp, input bit ramp, input bit abort_last);
        for (int k = 0; k < nsamp; k++) begin
            if ($urandom_range(0, 3) == 0) begin
                in_valid = 1'b0;
                step();
            end
            in_valid = 1'b1;
            if (ramp) begin
                in_re = 32'(k);
                in_im = 32'(-k);
            end else begin
                in_re = $urandom();
                in_im = $urandom();
            end
            abort_req = abort_last && (k == nsamp - 1);
            step();
            if (!(abort_last && (k == nsamp - 1))) begin
                model_re[rev3(k)] = in_re;
                model_im[rev3(k)] = in_im;
            end
            in_valid  = 1'b0;
            abort_req = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        n_checks++;
        if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", in_ready);
        else n_pass++;
        n_checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || core_start !== 1'b0 || core_abort !== 1'b0)
            $display("FAIL reset_ctrl: out_valid=%b busy=%b core_start=%b core_abort=%b want 0",
                     out_valid, busy, core_start, core_abort);
        else n_pass++;
        n_checks++;
        if (result !== 16'd0 || result_valid !== 1'b0 || frame_count !== 16'd0)
            $display("FAIL reset_result: result=%0d valid=%b frame_count=%0d want 0/0/0",
                     result, result_valid, frame_count);
        else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        step();
        n_checks++;
        if (in_ready !== 1'b1 || busy !== 1'b0)
            $display("FAIL post_reset_state: in_ready=%b busy=%b want 1/0", in_ready, busy);
        else n_pass++;
    endtask

    task automatic test_load();
        int exp_tab [N];
        exp_tab = '{0, 4, 2, 6, 1, 5, 3, 7};
        load_frame(N, 1'b1, 1'b0);
        n_checks++;
        if (in_ready !== 1'b0 || busy !== 1'b0)
            $display("FAIL load_wait_state: in_ready=%b busy=%b want 0/0", in_ready, busy);
        else n_pass++;
        for (int a = 0; a < N; a++) begin
            i_top = 3'(a);
            i_bot = 3'(N - 1 - a);
            #1;
            n_checks++;
            if (x_top_re !== 32'(exp_tab[a]) || x_top_re !== model_re[a])
                $display("FAIL load_re[%0d]: got %0d want %0d", a, x_top_re, exp_tab[a]);
            else n_pass++;
            n_checks++;
            if (x_top_im !== model_im[a] || x_bot_im !== model_im[N - 1 - a])
                $display("FAIL load_im[%0d]: got %h/%h want %h/%h", a, x_top_im, x_bot_im,
                         model_im[a], model_im[N - 1 - a]);
            else n_pass++;
            step();
        end
    endtask

    task automatic test_run();
        mode  = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        n_checks++;
        if (core_start !== 1'b1 || busy !== 1'b1)
            $display("FAIL run_first_cycle: core_start=%b busy=%b want 1/1", core_start, busy);
        else n_pass++;
        // Launch cycle: results presented here must not land.
        i_top = 3'd1; i_bot = 3'd3;
        y_top_re = 32'd555; y_top_im = 32'd555; y_bot_re = 32'd666; y_bot_im = 32'd666;
        step();
        for (int c = 0; c < 2; c++) begin
            n_checks++;
            if (core_start !== 1'b0 || busy !== 1'b1)
                $display("FAIL run_pulse_width[%0d]: core_start=%b busy=%b want 0/1", c,
                         core_start, busy);
            else n_pass++;
            i_top = 3'd0; i_bot = 3'd4;
            y_top_re = 32'd100; y_top_im = 32'(-100);
            y_bot_re = 32'd200; y_bot_im = 32'(-200);
            step();
        end
        model_re[0] = 32'd100; model_im[0] = 32'(-100);
        model_re[4] = 32'd200; model_im[4] = 32'(-200);
        // Done cycle: no write either.
        core_done = 1'b1;
        i_top = 3'd2; i_bot = 3'd6;
        y_top_re = 32'd777; y_top_im = 32'd777; y_bot_re = 32'd888; y_bot_im = 32'd888;
        step();
        core_done = 1'b0;
        fc_model++;
        n_checks++;
        if (out_valid !== 1'b1 || busy !== 1'b0 || frame_count !== 16'(fc_model))
            $display("FAIL run_done: out_valid=%b busy=%b frame_count=%0d want 1/0/%0d",
                     out_valid, busy, frame_count, fc_model);
        else n_pass++;
    endtask

    task automatic test_unload();
        int idx;
        int cyc;
        idx = 0;
        cyc = 0;
        while (idx < N && cyc < 100) begin
            out_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
            n_checks++;
            if (out_valid !== 1'b1 || out_index !== 3'(idx) || out_re !== model_re[idx] ||
                out_im !== model_im[idx] || out_last !== (idx == N - 1))
                $display("FAIL unload[%0d]: valid=%b index=%0d re=%h im=%h last=%b want 1/%0d/%h/%h/%b",
                         cyc, out_valid, out_index, out_re, out_im, out_last, idx,
                         model_re[idx], model_im[idx], (idx == N - 1));
            else n_pass++;
            step();
            if (out_ready) idx++;
            cyc++;
        end
        out_ready = 1'b0;
        n_checks++;
        if (idx !== N) $display("FAIL unload_count: accepted %0d want %0d", idx, N);
        else n_pass++;
        n_checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0)
            $display("FAIL unload_to_load: in_ready=%b out_valid=%b want 1/0", in_ready,
                     out_valid);
        else n_pass++;
    endtask

    task automatic test_hold();
        int addrs [7];
        logic [15:0] exp_res;
        load_frame(N, 1'b0, 1'b0);
        mode  = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;
        i_top = 3'd0; i_bot = 3'd1;
        y_top_re = $urandom(); y_top_im = $urandom(); y_bot_re = $urandom(); y_bot_im = $urandom();
        step();
        i_top = 3'd2; i_bot = 3'd3;
        y_top_re = 32'd70000; y_top_im = $urandom();
        y_bot_re = 32'(-70000); y_bot_im = $urandom();
        step();
        model_re[2] = y_top_re; model_im[2] = y_top_im;
        model_re[3] = y_bot_re; model_im[3] = y_bot_im;
        // Colliding addresses: the top result must win.
        i_top = 3'd5; i_bot = 3'd5;
        y_top_re = 32'd123; y_top_im = 32'd321; y_bot_re = 32'd999; y_bot_im = 32'd999;
        step();
        model_re[5] = 32'd123; model_im[5] = 32'd321;
        core_done = 1'b1;
        step();
        core_done = 1'b0;
        fc_model++;
        n_checks++;
        if (frame_count !== 16'(fc_model) || busy !== 1'b0 || in_ready !== 1'b0 ||
            out_valid !== 1'b0)
            $display("FAIL hold_entry: frame_count=%0d busy=%b in_ready=%b out_valid=%b want %0d/0/0/0",
                     frame_count, busy, in_ready, out_valid, fc_model);
        else n_pass++;
        for (int j = 0; j < 4; j++) addrs[j] = $urandom_range(0, N - 1);
        addrs[4] = 2; addrs[5] = 3; addrs[6] = 5;
        exp_res = 16'd0;
        for (int j = 0; j < 7; j++) begin
            inspect = 3'(addrs[j]);
            step();
            exp_res = sat_model(model_re[addrs[j]]);
            n_checks++;
            if (result_valid !== 1'b1 || result !== exp_res)
                $display("FAIL hold_inspect[%0d]: valid=%b result=%0d want 1/%0d", addrs[j],
                         result_valid, $signed(result), $signed(exp_res));
            else n_pass++;
        end
        start = 1'b1;
        step();
        start = 1'b0;
        n_checks++;
        if (busy !== 1'b0 || result_valid !== 1'b1 || core_start !== 1'b0)
            $display("FAIL hold_ignores_start: busy=%b valid=%b core_start=%b want 0/1/0",
                     busy, result_valid, core_start);
        else n_pass++;
        clear   = 1'b1;
        inspect = 3'd2;
        step();
        clear = 1'b0;
        n_checks++;
        if (result_valid !== 1'b0 || in_ready !== 1'b1 || result !== exp_res)
            $display("FAIL hold_clear: valid=%b in_ready=%b result=%0d want 0/1/%0d",
                     result_valid, in_ready, $signed(result), $signed(exp_res));
        else n_pass++;
    endtask

    task automatic test_abort_run();
        load_frame(N, 1'b0, 1'b0);
        mode  = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        // Present the buffer's own values so the aborted frame leaves no trace.
        i_top = 3'd0; i_bot = 3'd1;
        y_top_re = model_re[0]; y_top_im = model_im[0];
        y_bot_re = model_re[1]; y_bot_im = model_im[1];
        step();
        abort_req = 1'b1;
        step();
        abort_req = 1'b0;
        n_checks++;
        if (core_abort !== 1'b1 || in_ready !== 1'b1 || busy !== 1'b0 ||
            frame_count !== 16'(fc_model))
            $display("FAIL abort_run: core_abort=%b in_ready=%b busy=%b frame_count=%0d want 1/1/0/%0d",
                     core_abort, in_ready, busy, frame_count, fc_model);
        else n_pass++;
        step();
        n_checks++;
        if (core_abort !== 1'b0)
            $display("FAIL abort_pulse_width: core_abort=%b want 0", core_abort);
        else n_pass++;
    endtask

    task automatic test_abort_last();
        load_frame(N, 1'b0, 1'b1);
        n_checks++;
        if (in_ready !== 1'b1 || busy !== 1'b0)
            $display("FAIL abort_last_state: in_ready=%b busy=%b want 1/0", in_ready, busy);
        else n_pass++;
        for (int a = 0; a < N; a++) begin
            i_top = 3'(a);
            #1;
            n_checks++;
            if (x_top_re !== model_re[a] || x_top_im !== model_im[a])
                $display("FAIL abort_last_buf[%0d]: got %h/%h want %h/%h", a, x_top_re,
                         x_top_im, model_re[a], model_im[a]);
            else n_pass++;
            step();
        end
        // A fresh frame must start from write pointer 0.
        load_frame(N, 1'b0, 1'b0);
        n_checks++;
        if (in_ready !== 1'b0) $display("FAIL reload_wait: in_ready=%b want 0", in_ready);
        else n_pass++;
        for (int a = 0; a < N; a++) begin
            i_top = 3'(a);
            #1;
            n_checks++;
            if (x_top_re !== model_re[a])
                $display("FAIL reload_buf[%0d]: got %h want %h", a, x_top_re, model_re[a]);
            else n_pass++;
            step();
        end
    endtask

    task automatic test_done_at_start_and_reset();
        mode  = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        core_done = 1'b1;
        i_top = 3'd3; i_bot = 3'd6;
        y_top_re = ~model_re[3]; y_top_im = ~model_im[3];
        y_bot_re = ~model_re[6]; y_bot_im = ~model_im[6];
        step();
        core_done = 1'b0;
        fc_model++;
        n_checks++;
        if (out_valid !== 1'b1 || frame_count !== 16'(fc_model) || core_start !== 1'b0)
            $display("FAIL done_at_start: out_valid=%b frame_count=%0d core_start=%b want 1/%0d/0",
                     out_valid, frame_count, core_start, fc_model);
        else n_pass++;
        out_ready = 1'b1;
        for (int idx = 0; idx < 4; idx++) begin
            n_checks++;
            if (out_index !== 3'(idx) || out_re !== model_re[idx])
                $display("FAIL done_at_start_out[%0d]: index=%0d re=%h want %0d/%h", idx,
                         out_index, out_re, idx, model_re[idx]);
            else n_pass++;
            step();
        end
        out_ready = 1'b0;
        // Asynchronous reset in the middle of UNLOAD, away from the clock edge.
        #2;
        rst_n    = 1'b0;
        in_valid = 1'b1;
        in_re    = 32'hdead_beef;
        in_im    = 32'hdead_beef;
        #1;
        fc_model = 0;
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || frame_count !== 16'd0 || busy !== 1'b0)
            $display("FAIL reset_mid_unload: out_valid=%b in_ready=%b frame_count=%0d busy=%b want 0/1/0/0",
                     out_valid, in_ready, frame_count, busy);
        else n_pass++;
        step();
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        step();
        for (int a = 0; a < N; a++) begin
            i_top = 3'(a);
            #1;
            n_checks++;
            if (x_top_re !== model_re[a] || x_top_im !== model_im[a])
                $display("FAIL buffer_kept[%0d]: got %h/%h want %h/%h", a, x_top_re, x_top_im,
                         model_re[a], model_im[a]);
            else n_pass++;
            step();
        end
    endtask

    task automatic test_auto_start();
        logic [31:0] s_re [N];
        logic [31:0] s_im [N];
        for (int k = 0; k < N; k++) begin
            a_in_valid = 1'b1;
            a_in_re    = $urandom();
            a_in_im    = $urandom();
            s_re[k]    = a_in_re;
            s_im[k]    = a_in_im;
            step();
            if (k == N - 2) begin
                n_checks++;
                if (a_core_start !== 1'b0 || a_busy !== 1'b0)
                    $display("FAIL auto_early: core_start=%b busy=%b want 0/0", a_core_start,
                             a_busy);
                else n_pass++;
            end
        end
        a_in_valid = 1'b0;
        n_checks++;
        if (a_core_start !== 1'b1 || a_busy !== 1'b1 || a_in_ready !== 1'b0)
            $display("FAIL auto_start: core_start=%b busy=%b in_ready=%b want 1/1/0",
                     a_core_start, a_busy, a_in_ready);
        else n_pass++;
        step();
        n_checks++;
        if (a_core_start !== 1'b0)
            $display("FAIL auto_pulse_width: core_start=%b want 0", a_core_start);
        else n_pass++;
        a_core_done = 1'b1;
        step();
        a_core_done = 1'b0;
        n_checks++;
        if (a_out_valid !== 1'b1 || a_frame_count !== 16'd1)
            $display("FAIL auto_done: out_valid=%b frame_count=%0d want 1/1", a_out_valid,
                     a_frame_count);
        else n_pass++;
        a_out_ready = 1'b1;
        for (int idx = 0; idx < N; idx++) begin
            n_checks++;
            if (a_out_index !== 3'(idx) || a_out_re !== s_re[idx] || a_out_im !== s_im[idx])
                $display("FAIL auto_natural[%0d]: index=%0d re=%h im=%h want %0d/%h/%h", idx,
                         a_out_index, a_out_re, a_out_im, idx, s_re[idx], s_im[idx]);
            else n_pass++;
            step();
        end
        a_out_ready = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        fc_model = 0;
        rst_n = 1'b0;
        start = 1'b0; mode = 1'b0; clear = 1'b0; abort_req = 1'b0;
        in_valid = 1'b0; in_re = '0; in_im = '0;
        core_done = 1'b0; i_top = '0; i_bot = '0;
        y_top_re = '0; y_top_im = '0; y_bot_re = '0; y_bot_im = '0;
        out_ready = 1'b0; inspect = '0;
        a_start = 1'b0; a_mode = 1'b0; a_clear = 1'b0; a_abort = 1'b0;
        a_in_valid = 1'b0; a_in_re = '0; a_in_im = '0;
        a_core_done = 1'b0; a_i_top = '0; a_i_bot = '0;
        a_y_top_re = '0; a_y_top_im = '0; a_y_bot_re = '0; a_y_bot_im = '0;
        a_out_ready = 1'b0; a_inspect = '0;

        test_reset();
        test_load();
        test_run();
        test_unload();
        test_hold();
        test_abort_run();
        test_abort_last();
        test_done_at_start_and_reset();
        test_auto_start();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/fft_frame_ctrl.md
Name: fft_frame_ctrl

Overview:
- Parametrised frame controller around the in-place radix-2 FFT core (i_top/i_bot butterfly interface).
- Owns the complex sample buffer and streams N samples in, replacing the fixed init LUT.
- Launches the core and writes butterfly results back each cycle.
- Delivers results either as an output stream (continuous mode) or by random-access inspection with saturation (hold mode).

Parameters:
LOG2N, 8, log2 of FFT points; N = 2^LOG2N
DW, 32, signed sample width, real and imaginary parts
OUT_W, 16, width of the saturated inspection result
BITREV_IN, 1, 1 = store input sample k at address bitrev(k); 0 = natural order
AUTO_START, 0, 1 = launch the core as soon as the buffer is full; 0 = wait for Start

Ports:
Clk  in  1  clock, rising edge
Reset_n  in  1  asynchronous, active-low reset
Start  in  1  launch request, sampled in WAIT
Mode  in  1  0 = stream results out then reload; 1 = hold results for inspection; sampled on the core-done transition
Clear  in  1  leave HOLD and return to LOAD
Abort  in  1  from any state, discard the frame and return to LOAD
In_Valid  in  1  input sample valid
In_Ready  out  1  high in LOAD
In_Re, In_Im  in  DW  input sample
Core_Start  out  1  one-cycle launch pulse to the core
Core_Abort  out  1  one-cycle pulse when Abort is taken in RUN
Core_i_top, Core_i_bot  in  LOG2N  butterfly addresses from the core
Core_x_top_re/im, Core_x_bot_re/im  out  DW  X[i_top], X[i_bot], combinational read
Core_y_top_re/im, Core_y_bot_re/im  in  DW  butterfly results
Core_Done  in  1  core finished
Out_Valid  out  1  high in UNLOAD
Out_Ready  in  1  downstream accept
Out_Re, Out_Im  out  DW  X[rd_ptr]
Out_Index  out  LOG2N  rd_ptr
Out_Last  out  1  Out_Valid and rd_ptr == N-1
Inspect  in  LOG2N  inspection address
Result  out  OUT_W  saturated X_Re[Inspect]
Result_Valid  out  1  Result is current
Busy  out  1  state is RUN
Frame_Count  out  16  completed frames, wraps at 65535 -> 0

Behaviour:
- States: LOAD, WAIT, RUN, UNLOAD, HOLD; one-hot encoding.
- Reset_n low forces:
  - state = LOAD; wr_ptr = rd_ptr = 0; Frame_Count = 0.
  - Result = 0; Result_Valid = 0; Core_Start = 0; Core_Abort = 0.
  - The buffer itself is not reset.
  - No writes occur while Reset_n is low.
- LOAD:
  - A sample is accepted on In_Valid & In_Ready.
  - It is written to address bitrev(wr_ptr) if BITREV_IN = 1, else wr_ptr; X_Im takes In_Im.
  - wr_ptr increments on each accept.
  - On accept with wr_ptr == N-1: wr_ptr -> 0, and go to WAIT, or to RUN if AUTO_START = 1.
- WAIT: Start -> RUN.
- Core_Start:
  - Registered pulse, high for exactly the first cycle in RUN, on every entry to RUN.
- RUN:
  - While Core_Done = 0, each cycle write Core_y_top_* to X[i_top] and Core_y_bot_* to X[i_bot].
  - If i_top == i_bot, the top write wins.
  - The cycle carrying Core_Start performs no write.
  - Core_Done = 1: no write; Frame_Count increments; go to UNLOAD if Mode = 0, else HOLD.
- UNLOAD:
  - Out_* are driven combinationally from X[rd_ptr].
  - rd_ptr advances on Out_Valid & Out_Ready.
  - Out_Valid must not drop, and Out_* must not change, while Out_Ready = 0.
  - Accept with Out_Last -> rd_ptr = 0, then LOAD.
- HOLD:
  - Each cycle, Result <= sat(X_Re[Inspect]) (1-cycle latency) and Result_Valid <= 1.
  - sat() clamps to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
  - Clear -> LOAD with Result_Valid <= 0; Result keeps its last value.
  - Start is ignored in HOLD.
- Abort:
  - Highest priority; from any state go to LOAD with wr_ptr = rd_ptr = 0.
  - Frame_Count is unchanged.
  - Abort in RUN pulses Core_Abort for one cycle.
  - Abort in the same cycle as the final load accept: the sample is dropped, state is LOAD.
- Simultaneous events:
  - Clear and Abort in HOLD: Abort semantics.
  - Core_Done in the Core_Start cycle: treated as done, with zero writes.
- Outputs outside their active state:
  - In_Ready = 0 outside LOAD.
  - Out_Valid = 0 outside UNLOAD.
  - Result_Valid = 0 outside HOLD.
- Arithmetic: no arithmetic on the data path except sat(); data widths pass through unmodified.

Test Plan:
- LOG2N=3, BITREV_IN=1: feed samples 0..7 (Re = k, Im = -k) -> buffer holds X_Re = {0,4,2,6,1,5,3,7}, X_Im negated; state WAIT; In_Ready = 0.
- Start with a stub core:
  - Stub drives i_top=0, i_bot=4, y = 100/200 for 2 cycles, then Done.
  - Required: Core_Start high only in the first RUN cycle; X_Re[0]=100, X_Re[4]=200; Frame_Count = 1.
  - Mode=0: go to UNLOAD.
- UNLOAD with Out_Ready toggled 1,0,0,1,...:
  - Indices 0..7 in order, data held stable while stalled.
  - Out_Last only on index 7; LOAD one cycle after that accept.
- Mode=1, OUT_W=16, X_Re[2] = 70000, X_Re[3] = -70000, X_Re[5] = 123:
  - Inspect 2/3/5 -> Result 32767 / -32768 / 123 one cycle later, Result_Valid = 1.
  - Clear -> LOAD, Result_Valid = 0.
- Abort:
  - Abort mid-RUN -> Core_Abort pulse, LOAD, wr_ptr = 0, Frame_Count unchanged.
  - Abort on the 8th load accept -> LOAD, sample dropped.
- Reset_n asserted mid-UNLOAD -> immediately state LOAD, Out_Valid = 0, Frame_Count = 0.
- AUTO_START=1 -> Core_Start pulses the cycle after the 8th accept, with no Start.
